fu_issue_router: RTL
====================

# fu_issue_router

Parametrised superscalar issue stage between the reservation station and execute. Each cycle it takes `WIDTH` candidate RS entries and classifies each by `alu_func` as ALU, MUL or OTHER. It routes them onto `NUM_ALU` ALU ports, `NUM_MUL` multiplier ports and one OTHER lane per slot, honouring ALU stalls and multi-cycle multiplier occupancy. It returns per-slot `delete_confirm` to the RS and uses a round-robin starting slot so that denied entries are served first on retry.

## Interface
- `WIDTH`, default 2: RS candidate slots per cycle; must be ≥1.
- `NUM_ALU`, default 2: ALU ports; must be ≥1.
- `NUM_MUL`, default 1: multiplier ports; must be ≥1.
- `MUL_LAT`, default 4: multiplier occupancy in cycles; must be ≥1.
- `MUL_PIPELINED`, default 0: 1 means a multiplier accepts one op every cycle, and occupancy tracking is disabled.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `rollback_en`  in  1  ROB squash; flushes everything.
- `issue_packet`  in  `RS_OBJ[WIDTH]`  candidates; slot 0 is oldest; `.packet.valid` qualifies each slot.
- `ld_in_ex`  in  1  load occupying execute.
- `data_input`  in  1  load data returned.
- `stall_alu`  in  `NUM_ALU`  1 = that ALU refuses a new op this cycle.
- `alu_packet`  out  `RS_OBJ[NUM_ALU]`  op per ALU.
- `alu_valid`  out  `NUM_ALU`.
- `mul_packet`  out  `RS_OBJ[NUM_MUL]`.
- `mul_valid`  out  `NUM_MUL`.
- `oth_packet`  out  `RS_OBJ[WIDTH]`  non-ALU/MUL op per slot.
- `oth_valid`  out  `WIDTH`.
- `delete_confirm`  out  `WIDTH`  1 = slot granted; the RS frees the entry.
- `mul_busy`  out  `NUM_MUL`  debug/perf: unit occupied.

## Operation
- **Classification:**
  - Invalid slot → NONE.
  - `ALU_ADD, SUB, AND, SLT, SLTU, OR, XOR, SRL, SLL, SRA` → ALU.
  - `ALU_MUL, MULH, MULHSU, MULHU` → MUL.
  - Any other function → OTHER.
- **Priority order:** slots `rr_ptr, rr_ptr+1, …` modulo `WIDTH`.
- **ALU allocation:** each ALU-class slot, in priority order, takes the lowest-index ALU with `stall_alu=0` that is not yet taken. When none remains, the slot is denied.
- **MUL allocation:** same scheme over multipliers where `busy_cnt==0` (or any unit not yet taken this cycle when `MUL_PIPELINED=1`).
- **OTHER:** always granted on `oth_*[slot]`.
- **`delete_confirm[i]`:** 1 iff slot i was granted. NONE and denied slots give 0.
- **`rr_ptr` update:** set to the index of the first denied valid slot in priority order. If no slot was denied, set to 0.
- **Busy tracking (`MUL_PIPELINED=0`):**
  - On grant, `busy_cnt <= MUL_LAT-1`.
  - Otherwise the counter decrements while non-zero.
  - `mul_busy = (busy_cnt != 0)`.
  - `MUL_LAT=1` never produces busy.
- **Load hold** (`ld_in_ex & !data_input`):
  - No grants; every valid and every `delete_confirm` bit is 0.
  - Packets hold their value.
  - `rr_ptr` holds; `busy_cnt` still decrements.
- **Flush** (`reset | rollback_en`):
  - All packets 0, all valids 0, `delete_confirm` 0.
  - `busy_cnt` 0, `rr_ptr` 0.
  - Flush has priority over load hold.
- **Ungranted ports:** their valid is 0 and their packet is 0.

## Timing
- All outputs are registered. Inputs sampled in cycle N produce outputs, including `delete_confirm`, in cycle N+1. Issue latency is 1.
- `stall_alu` and `busy_cnt` are evaluated in the same cycle as the grant decision.
- A MUL granted in cycle N makes that unit unavailable for N+1 … N+MUL_LAT-1. It becomes grantable again in cycle N+MUL_LAT.
- Each output valid is a single-cycle pulse per grant. The RS must drop or replace a confirmed entry before the next sample; a re-presented entry is treated as a new op.
- Reset state for every output: packets 0, `alu_valid`/`mul_valid`/`oth_valid` 0, `delete_confirm` 0, `mul_busy` 0.

## Structure
- **Shared package `sys_defs`:**
  - Already provides `RS_OBJ`, the `ALU_FUNC` enum and `` `WIDTH ``.
  - Add `typedef enum logic [1:0] {FU_NONE, FU_ALU, FU_MUL, FU_OTHER} fu_class_t;`.
  - Add `function fu_class_t classify_fu(RS_OBJ)`.
- **Sub-module `mul_busy_tracker`** (params `NUM_MUL`, `MUL_LAT`, `MUL_PIPELINED`):
  - Inputs: `clock`, `reset`, `flush`, `grant[NUM_MUL]`.
  - Output: `free[NUM_MUL]`.
  - Holds the per-unit counters; counter width is `$clog2(MUL_LAT+1)`.
- The top level holds classification, the allocation loops, `rr_ptr` (`$clog2(WIDTH)` bits, minimum 1) and the output registers.

## Test plan
- **Two ALU ops, no stall** (`WIDTH=2, NUM_ALU=2`): ADD(s0), SUB(s1), `stall_alu=00` → next cycle `alu_valid=11`, `alu_packet[0]=s0`, `alu_packet[1]=s1`, `delete_confirm=11`.
- **ALU contention and round-robin:** ADD, ADD with `stall_alu=01` → `alu_packet[1]=s0`, `delete_confirm=01`, `rr_ptr=1`. Same inputs next cycle with `stall_alu=00` → both granted, `rr_ptr=0`.
- **Non-pipelined MUL occupancy** (`MUL_LAT=4`): MUL at cycle 0 is granted; MULs presented at cycles 1–3 get `delete_confirm=0`; the MUL presented at cycle 4 is granted; `mul_busy` is 1 during cycles 1–3.
- **Mixed classes:** MUL(s0) plus a branch-type op (s1) → `mul_valid[0]=1`, `oth_valid[1]=1`, `delete_confirm=11`.
- **Load hold:** `ld_in_ex=1, data_input=0` with valid ADDs → all valids 0, `delete_confirm=00`. Then `data_input=1` → issue resumes.
- **Rollback during MUL busy:** set `rollback_en` at cycle 2 after a MUL grant → outputs 0, `mul_busy=0`. A MUL at cycle 3 is granted.

Source files
------------

// File: rtl/fu_issue_router_pkg.sv
// Shared issue-stage types: RS entry layout, ALU function codes and FU classification.
package fu_issue_router_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, ALU_BRANCH, ALU_JAL, ALU_LOAD, ALU_STORE
  } ALU_FUNC;

  typedef struct packed {
    logic        valid;
    ALU_FUNC     alu_func;
    logic [31:0] pc;
    logic [4:0]  dest_reg;
  } RS_PACKET;

  typedef struct packed {
    RS_PACKET   packet;
    logic [5:0] rob_idx;
  } RS_OBJ;

  typedef enum logic [1:0] {FU_NONE, FU_ALU, FU_MUL, FU_OTHER} fu_class_t;

  function automatic fu_class_t classify_fu(RS_OBJ obj);
    fu_class_t cls;
    if (!obj.packet.valid) begin
      cls = FU_NONE;
    end else begin
      case (obj.packet.alu_func)
        ALU_ADD, ALU_SUB, ALU_AND, ALU_SLT, ALU_SLTU,
        ALU_OR, ALU_XOR, ALU_SRL, ALU_SLL, ALU_SRA:  cls = FU_ALU;
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU:    cls = FU_MUL;
        default:                                     cls = FU_OTHER;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/fu_issue_router_if.sv
// Bundle between the reservation station / execute units (master) and the issue router (slave).
interface fu_issue_router_if import fu_issue_router_pkg::*; #(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned NUM_ALU = 2,
  parameter int unsigned NUM_MUL = 1
) ();

  logic                    rollback_en;
  logic                    ld_in_ex;
  logic                    data_input;
  logic [NUM_ALU-1:0]      stall_alu;
  RS_OBJ [WIDTH-1:0]       issue_packet;

  RS_OBJ [NUM_ALU-1:0]     alu_packet;
  logic [NUM_ALU-1:0]      alu_valid;
  RS_OBJ [NUM_MUL-1:0]     mul_packet;
  logic [NUM_MUL-1:0]      mul_valid;
  RS_OBJ [WIDTH-1:0]       oth_packet;
  logic [WIDTH-1:0]        oth_valid;
  logic [WIDTH-1:0]        delete_confirm;
  logic [NUM_MUL-1:0]      mul_busy;

  modport master (
    output rollback_en, ld_in_ex, data_input, stall_alu, issue_packet,
    input  alu_packet, alu_valid, mul_packet, mul_valid, oth_packet, oth_valid,
    input  delete_confirm, mul_busy
  );

  modport slave (
    input  rollback_en, ld_in_ex, data_input, stall_alu, issue_packet,
    output alu_packet, alu_valid, mul_packet, mul_valid, oth_packet, oth_valid,
    output delete_confirm, mul_busy
  );

endinterface

// File: rtl/fu_issue_router_mul_busy_tracker.sv
// Per-multiplier occupancy counters; a unit is free once its counter has drained to zero.
module fu_issue_router_mul_busy_tracker #(
  parameter int unsigned NUM_MUL       = 1,
  parameter int unsigned MUL_LAT       = 4,
  parameter bit          MUL_PIPELINED = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [NUM_MUL-1:0] grant,
  output logic [NUM_MUL-1:0] free
);

  localparam int unsigned CntW = $clog2(MUL_LAT + 1);

  if (MUL_PIPELINED) begin : g_pipelined
    assign free = '1;
  end else begin : g_counted
    logic [NUM_MUL-1:0][CntW-1:0] busy_cnt_q, busy_cnt_d;

    always_comb begin
      busy_cnt_d = busy_cnt_q;
      for (int m = 0; m < NUM_MUL; m++) begin
        if (flush) begin
          busy_cnt_d[m] = '0;
        end else if (grant[m]) begin
          // The grant cycle itself counts as the first cycle of occupancy.
          busy_cnt_d[m] = CntW'(MUL_LAT - 1);
        end else if (busy_cnt_q[m] != '0) begin
          busy_cnt_d[m] = busy_cnt_q[m] - CntW'(1);
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        busy_cnt_q <= '0;
      end else begin
        busy_cnt_q <= busy_cnt_d;
      end
    end

    for (genvar m = 0; m < NUM_MUL; m++) begin : g_free
      assign free[m] = (busy_cnt_q[m] == '0);
    end
  end

endmodule

// File: rtl/fu_issue_router.sv
// Superscalar issue stage: classifies RS candidates and routes them onto ALU, MUL and OTHER lanes
// with round-robin slot priority so denied entries are served first on retry.
module fu_issue_router import fu_issue_router_pkg::*; #(
  parameter int unsigned WIDTH         = 2,
  parameter int unsigned NUM_ALU       = 2,
  parameter int unsigned NUM_MUL       = 1,
  parameter int unsigned MUL_LAT       = 4,
  parameter bit          MUL_PIPELINED = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  fu_issue_router_if.slave  bus
);

  localparam int unsigned PtrW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned SumW = PtrW + 1;

  logic flush, hold;
  assign flush = reset | bus.rollback_en;
  assign hold  = bus.ld_in_ex & ~bus.data_input;

  RS_OBJ [NUM_ALU-1:0] alu_packet_q, alu_packet_d;
  logic  [NUM_ALU-1:0] alu_valid_q, alu_valid_d;
  RS_OBJ [NUM_MUL-1:0] mul_packet_q, mul_packet_d;
  logic  [NUM_MUL-1:0] mul_valid_q, mul_valid_d;
  RS_OBJ [WIDTH-1:0]   oth_packet_q, oth_packet_d;
  logic  [WIDTH-1:0]   oth_valid_q, oth_valid_d;
  logic  [WIDTH-1:0]   delete_q, delete_d;
  logic  [PtrW-1:0]    rr_ptr_q, rr_ptr_d;

  logic  [NUM_MUL-1:0] mul_free, mul_grant;
  logic  [SumW-1:0]    sum;
  logic  [PtrW-1:0]    slot;
  logic                found, denied_seen;
  fu_class_t           cls;

  always_comb begin
    alu_packet_d = '0;
    alu_valid_d  = '0;
    mul_packet_d = '0;
    mul_valid_d  = '0;
    oth_packet_d = '0;
    oth_valid_d  = '0;
    delete_d     = '0;
    rr_ptr_d     = '0;
    mul_grant    = '0;
    sum          = '0;
    slot         = '0;
    found        = 1'b0;
    denied_seen  = 1'b0;
    cls          = FU_NONE;

    if (flush) begin
      // Everything stays at its zero default.
    end else if (hold) begin
      alu_packet_d = alu_packet_q;
      mul_packet_d = mul_packet_q;
      oth_packet_d = oth_packet_q;
      rr_ptr_d     = rr_ptr_q;
    end else begin
      for (int k = 0; k < WIDTH; k++) begin
        sum = {1'b0, rr_ptr_q} + SumW'(k);
        if (sum >= SumW'(WIDTH)) sum = sum - SumW'(WIDTH);
        slot  = sum[PtrW-1:0];
        cls   = classify_fu(bus.issue_packet[slot]);
        found = 1'b0;
        case (cls)
          FU_ALU: begin
            // alu_valid_d doubles as the "already taken this cycle" mask.
            for (int a = 0; a < NUM_ALU; a++) begin
              if (!found && !bus.stall_alu[a] && !alu_valid_d[a]) begin
                alu_valid_d[a]  = 1'b1;
                alu_packet_d[a] = bus.issue_packet[slot];
                delete_d[slot]  = 1'b1;
                found           = 1'b1;
              end
            end
          end
          FU_MUL: begin
            for (int m = 0; m < NUM_MUL; m++) begin
              if (!found && mul_free[m] && !mul_grant[m]) begin
                mul_grant[m]    = 1'b1;
                mul_valid_d[m]  = 1'b1;
                mul_packet_d[m] = bus.issue_packet[slot];
                delete_d[slot]  = 1'b1;
                found           = 1'b1;
              end
            end
          end
          FU_OTHER: begin
            oth_valid_d[slot]  = 1'b1;
            oth_packet_d[slot] = bus.issue_packet[slot];
            delete_d[slot]     = 1'b1;
            found              = 1'b1;
          end
          default: found = 1'b1;
        endcase
        if (!found && !denied_seen) begin
          rr_ptr_d    = slot;
          denied_seen = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    alu_packet_q <= alu_packet_d;
    alu_valid_q  <= alu_valid_d;
    mul_packet_q <= mul_packet_d;
    mul_valid_q  <= mul_valid_d;
    oth_packet_q <= oth_packet_d;
    oth_valid_q  <= oth_valid_d;
    delete_q     <= delete_d;
    rr_ptr_q     <= rr_ptr_d;
  end

  fu_issue_router_mul_busy_tracker #(
    .NUM_MUL       (NUM_MUL),
    .MUL_LAT       (MUL_LAT),
    .MUL_PIPELINED (MUL_PIPELINED)
  ) u_mul_busy (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .grant (mul_grant),
    .free  (mul_free)
  );

  assign bus.alu_packet     = alu_packet_q;
  assign bus.alu_valid      = alu_valid_q;
  assign bus.mul_packet     = mul_packet_q;
  assign bus.mul_valid      = mul_valid_q;
  assign bus.oth_packet     = oth_packet_q;
  assign bus.oth_valid      = oth_valid_q;
  assign bus.delete_confirm = delete_q;
  assign bus.mul_busy       = ~mul_free;

endmodule
